// File: rtl/seg_pkg.sv
// Shared seven-segment constants for the display encoder and the scan decoder.
package seg_pkg;

  localparam int NUM_DIGITS = 4;

  // Active-low cathode patterns, bit 6 = segment a ... bit 0 = segment g.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100,  // 9
    7'b0001000,  // A
    7'b1100000,  // b
    7'b0110001,  // C
    7'b1000010,  // d
    7'b0110000,  // E
    7'b0111000   // F
  };

  // True when exactly one active-low anode is driven.
  function automatic logic one_low(input logic [NUM_DIGITS-1:0] an);
    return ($countones(~an) == 1);
  endfunction

  // Index of the lowest active-low anode (meaningful only when one_low is true).
  function automatic logic [1:0] low_index(input logic [NUM_DIGITS-1:0] an);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (!an[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg_to_hex.sv
// Combinational seven-segment pattern to hex nibble decoder.
module seg_to_hex
  import seg_pkg::*;
(
  input  logic [6:0] pat,
  output logic       hit,
  output logic       blank,
  output logic [3:0] nibble
);

  // Match the pattern against every legal glyph and the blank pattern.
  always_comb begin
    hit    = 1'b0;
    blank  = (pat == SEG_BLANK);
    nibble = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (pat == SEG_GLYPH[i]) begin
        hit    = 1'b1;
        nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers the 4-digit hex value shown on a multiplexed seven-segment display
// by watching its cathode and anode lines.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  ca,
  input  logic [3:0]  an,
  output logic [15:0] value,
  output logic        value_valid,
  output logic [3:0]  blank_mask,
  output logic        digit_err
);

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  // {an, ca} as one word; an occupies bits [10:7].
  logic [10:0] sync_p0;
  logic [10:0] sync_p1;
  logic [10:0] hist_p2;
  logic [7:0]  cnt_p2;
  logic [7:0]  cnt_nxt;
  logic        first_p2;

  logic [3:0]  an_h;
  logic [6:0]  ca_h;
  logic        accept;
  logic        good;
  logic [1:0]  idx;
  logic        dec_hit;
  logic        dec_blank;
  logic [3:0]  dec_nib;

  logic [15:0] slot_p3;
  logic [3:0]  blank_p3;
  logic [3:0]  seen_p3;
  logic [3:0]  seen_nxt;

  // Stability counter next value: restart on change, saturate at STABLE.
  always_comb begin
    cnt_nxt = cnt_p2;
    if (sync_p1 != hist_p2) begin
      cnt_nxt = 8'd1;
    end else if (cnt_p2 != STABLE) begin
      cnt_nxt = cnt_p2 + 8'd1;
    end
  end

  // Synchronizer, one-cycle history of the synchronized pair, stability counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0  <= '1;
      sync_p1  <= '1;
      hist_p2  <= '1;
      cnt_p2   <= 8'd0;
      first_p2 <= 1'b0;
    end else begin
      sync_p0  <= {an, ca};
      sync_p1  <= sync_p0;
      hist_p2  <= sync_p1;
      cnt_p2   <= cnt_nxt;
      first_p2 <= (cnt_nxt == STABLE) && (cnt_p2 != STABLE);
    end
  end

  // hist_p2 holds the pattern that just completed its stable run.
  assign an_h   = hist_p2[10:7];
  assign ca_h   = hist_p2[6:0];
  assign accept = first_p2 && one_low(an_h);
  assign idx    = low_index(an_h);
  assign good   = accept && (dec_hit || dec_blank);

  seg_to_hex u_seg_to_hex (
    .pat    (ca_h),
    .hit    (dec_hit),
    .blank  (dec_blank),
    .nibble (dec_nib)
  );

  // A full frame starts a new one; a digit accepted that same cycle belongs to it.
  always_comb begin
    seen_nxt = (seen_p3 == 4'hF) ? 4'h0 : seen_p3;
    if (good) seen_nxt[idx] = 1'b1;
  end

  // Digit slots, frame tracking and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_p3     <= 16'h0000;
      blank_p3    <= 4'h0;
      seen_p3     <= 4'h0;
      value       <= 16'h0000;
      blank_mask  <= 4'h0;
      value_valid <= 1'b0;
      digit_err   <= 1'b0;
    end else begin
      seen_p3     <= seen_nxt;
      value_valid <= (seen_p3 == 4'hF);
      digit_err   <= accept && !dec_hit && !dec_blank;
      if (seen_p3 == 4'hF) begin
        value      <= slot_p3;
        blank_mask <= blank_p3;
      end
      if (good) begin
        slot_p3[idx*4 +: 4] <= dec_hit ? dec_nib : 4'h0;
        blank_p3[idx]       <= dec_blank;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder with STABLE_CYCLES = 4.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  ca;
  logic [3:0]  an;
  logic [15:0] value;
  logic        value_valid;
  logic [3:0]  blank_mask;
  logic        digit_err;

  always #5 clk = ~clk;

  seg_scan_decoder #(.STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .ca          (ca),
    .an          (an),
    .value       (value),
    .value_valid (value_valid),
    .blank_mask  (blank_mask),
    .digit_err   (digit_err)
  );

  localparam logic [6:0] G [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  localparam logic [6:0] BL  = 7'b1111111;
  localparam logic [6:0] BAD = 7'b1111110;

  typedef struct packed {
    logic [3:0][6:0] pats;   // pats[i] shown on digit i
    logic [15:0]     val;
    logic [3:0]      mask;
  } vec_t;

  typedef struct packed {
    logic [15:0] val;
    logic [3:0]  mask;
  } frame_t;

  vec_t   vecs [4];
  frame_t sbq [$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int valid_cyc = 0;
  int change_cyc = 0;
  int v0, e0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_frame(input logic [15:0] v, input logic [3:0] m);
    frame_t f;
    f.val  = v;
    f.mask = m;
    sbq.push_back(f);
  endtask

  task automatic scan(input int idx, input logic [6:0] pat, input int hold);
    @(posedge clk);
    #2;
    an      = 4'hF;
    an[idx] = 1'b0;
    ca      = pat;
    change_cyc = cyc;
    repeat (hold - 1) @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #2;
    an = 4'hF;
    ca = BL;
    repeat (n - 1) @(posedge clk);
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard consumer: every value_valid pops one expected frame.
  always @(negedge clk) begin : mon
    frame_t f;
    if (!reset) begin
      if (value_valid) begin
        valid_cnt++;
        valid_cyc = cyc;
        if (sbq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_valid: got value %0h, expected no frame", value);
        end else begin
          f = sbq.pop_front();
          check("frame_value", 32'(value), 32'(f.val));
          check("frame_mask", 32'(blank_mask), 32'(f.mask));
        end
      end
      if (digit_err) err_cnt++;
    end
  end

  initial begin
    reset = 1'b1;
    an    = 4'hF;
    ca    = BL;

    vecs[0].pats = {G[1], G[2], G[3], G[4]};
    vecs[0].val  = 16'h1234;
    vecs[0].mask = 4'b0000;
    vecs[1].pats = {BL, BL, G[10], G[15]};
    vecs[1].val  = 16'h00AF;
    vecs[1].mask = 4'b1100;
    vecs[2].pats = {G[8], G[9], G[14], G[0]};
    vecs[2].val  = 16'h89E0;
    vecs[2].mask = 4'b0000;
    vecs[3].pats = {G[12], G[13], G[11], BL};
    vecs[3].val  = 16'hCDB0;
    vecs[3].mask = 4'b0001;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_value", 32'(value), 32'h0);
    check("reset_mask", 32'(blank_mask), 32'h0);
    check("reset_valid", 32'(value_valid), 32'h0);
    check("reset_err", 32'(digit_err), 32'h0);
    @(posedge clk);
    #2 reset = 1'b0;

    // Table-driven full frames, digit 0 first, digit 3 last.
    for (int i = 0; i < 4; i++) begin
      expect_frame(vecs[i].val, vecs[i].mask);
      v0 = valid_cnt;
      for (int d = 0; d < 4; d++) scan(d, vecs[i].pats[d], 10);
      idle(4);
      check("vec_valid_count", 32'(valid_cnt - v0), 32'd1);
      check("vec_value", 32'(value), 32'(vecs[i].val));
      if (i == 0) check("latency", 32'(valid_cyc - change_cyc), 32'd8);
    end

    // Digits held too briefly are never accepted.
    v0 = valid_cnt;
    e0 = err_cnt;
    for (int r = 0; r < 2; r++)
      for (int d = 0; d < 4; d++) scan(d, G[d + 1], 3);
    idle(10);
    check("short_hold_valid", 32'(valid_cnt - v0), 32'd0);
    check("short_hold_err", 32'(err_cnt - e0), 32'd0);

    // Illegal pattern on digit 2 blocks the frame until it is rescanned.
    expect_frame(16'h9765, 4'b0000);
    v0 = valid_cnt;
    e0 = err_cnt;
    scan(0, G[5], 10);
    scan(1, G[6], 10);
    scan(2, BAD, 10);
    scan(3, G[9], 10);
    idle(4);
    check("bad_glyph_err", 32'(err_cnt - e0), 32'd1);
    check("bad_glyph_no_valid", 32'(valid_cnt - v0), 32'd0);
    scan(2, G[7], 10);
    idle(4);
    check("rescan_valid", 32'(valid_cnt - v0), 32'd1);

    // A digit accepted twice keeps its newest value.
    expect_frame(16'h5432, 4'b0000);
    v0 = valid_cnt;
    scan(0, G[1], 10);
    scan(0, G[2], 10);
    scan(1, G[3], 10);
    scan(2, G[4], 10);
    scan(3, G[5], 10);
    idle(4);
    check("overwrite_valid", 32'(valid_cnt - v0), 32'd1);

    // All-selected and none-selected anodes mid-frame are ignored.
    expect_frame(16'hD0B7, 4'b0000);
    v0 = valid_cnt;
    e0 = err_cnt;
    scan(0, G[7], 10);
    scan(1, G[11], 10);
    @(posedge clk);
    #2;
    an = 4'h0;
    ca = 7'h00;
    repeat (19) @(posedge clk);
    #2;
    an = 4'hF;
    ca = BAD;
    repeat (20) @(posedge clk);
    check("multi_sel_valid", 32'(valid_cnt - v0), 32'd0);
    check("multi_sel_err", 32'(err_cnt - e0), 32'd0);
    check("multi_sel_value", 32'(value), 32'h5432);
    scan(2, G[0], 10);
    scan(3, G[13], 10);
    idle(4);
    check("multi_sel_resume", 32'(valid_cnt - v0), 32'd1);

    // Reset mid-frame discards the partial digits.
    v0 = valid_cnt;
    scan(0, G[1], 10);
    scan(1, G[2], 10);
    scan(2, G[3], 10);
    @(posedge clk);
    #2;
    reset = 1'b1;
    an    = 4'hF;
    ca    = BL;
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("midreset_value", 32'(value), 32'h0);
    check("midreset_mask", 32'(blank_mask), 32'h0);
    scan(3, G[4], 10);
    idle(10);
    check("midreset_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("midreset_value_hold", 32'(value), 32'h0);

    check("scoreboard_empty", 32'(sbq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 The block SHALL have one parameter: STABLE_CYCLES, default 4, giving the consecutive identical samples required before a digit is accepted; legal range is 2..255.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all flops are on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port ca, input, 7 bits: active-low segment cathodes, ca[6]=a through ca[0]=g, asynchronous to clk.
REQ-005 The block SHALL have port an, input, 4 bits: active-low digit anodes, an[i] low selects digit i (digit 3 is leftmost), asynchronous to clk.
REQ-006 The block SHALL have port value, output, 16 bits: last complete frame, with digit i in value[4i+3:4i].
REQ-007 The block SHALL have port value_valid, output, 1 bit: one-cycle pulse when value updates.
REQ-008 The block SHALL have port blank_mask, output, 4 bits: bit i is set when digit i was blank in the last frame; it updates together with value.
REQ-009 The block SHALL have port digit_err, output, 1 bit: one-cycle pulse when an accepted pattern is neither a legal glyph nor blank.

Function
REQ-010 ca and an SHALL pass through a two-flop synchronizer; all further logic SHALL use only the second-stage pair {an_s, ca_s}.
REQ-011 A stability counter SHALL reset to 1 on any cycle where {an_s, ca_s} differs from its previous-cycle value, increment otherwise, and saturate at STABLE_CYCLES.
REQ-012 An accept event SHALL occur on exactly the cycle the counter first reaches STABLE_CYCLES, and only if an_s has exactly one bit low; an accept event SHALL occur at most once per stable period.
REQ-013 When an_s is all ones or has more than one bit low, the block SHALL take no action and SHALL update no state other than the counter.
REQ-014 Decode (active-low) SHALL be: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000, blank=1111111.
REQ-015 On accept of a glyph, the block SHALL write the nibble into slot i, clear blank bit i, and set seen[i] at the next edge.
REQ-016 On accept of blank, the block SHALL write nibble 0 into slot i, set blank bit i, and set seen[i].
REQ-017 On accept of any other pattern, the block SHALL pulse digit_err at the next edge and SHALL leave slot i and seen[i] unchanged.
REQ-018 A repeated accept of a digit already marked in seen SHALL overwrite its slot with the newest data.
REQ-019 When seen equals 1111, at the next edge value and blank_mask SHALL load from the slots, value_valid SHALL pulse high for one cycle, and seen SHALL clear to 0000.
REQ-020 If an accept coincides with the seen-clear cycle, the new digit SHALL be recorded in the new frame, so seen becomes only that digit's bit.
REQ-021 Latency SHALL be exactly 2 (synchronizer) + STABLE_CYCLES + 1 (slot write) + 1 (frame publish) cycles from an input change to value_valid, when that input completes the frame.
REQ-022 Outputs SHALL be registered, with no combinational path from ca or an to any output.

Reset
REQ-023 While reset is high, the block SHALL clear synchronizer flops to all ones, counter to 0, slots to 0, seen to 0000, value to 0x0000, blank_mask to 0000, value_valid to 0, and digit_err to 0.
REQ-024 Reset asserted mid-frame SHALL discard partial digits; no value_valid SHALL occur until four fresh accepts after reset deassertion.

Structure
REQ-025 Package seg_pkg SHALL hold the 16 glyph constants, SEG_BLANK (1111111), and the digit count (4); the encoder side of the display SHALL use the same constants.
REQ-026 Combinational sub-module seg_to_hex SHALL map a 7-bit pattern to {hit, blank, nibble[3:0]}; seg_scan_decoder SHALL instantiate it once.

Verification
REQ-027 With STABLE_CYCLES=4, scan an=1110/1101/1011/0111 showing 4, 3, 2, 1, each held 10 cycles -> exactly one value_valid with value=0x1234, blank_mask=0000, at cycle 2+4+1+1=8 after the digit-3 change.
REQ-028 Hold each digit only 3 cycles with STABLE_CYCLES=4 -> no accepts, no value_valid, no digit_err.
REQ-029 Drive digit 2 with ca=1111110 while the other digits are legal -> one digit_err pulse, and no value_valid until digit 2 is rescanned with a legal glyph.
REQ-030 Scan a frame with digits 3 and 2 blank and digits 1 and 0 showing A and F -> value=0x00AF, blank_mask=1100.
REQ-031 Assert reset for 1 cycle after three digits are accepted, then scan only the fourth digit -> no value_valid; value stays 0x0000.
REQ-032 Drive an=0000 (all selected) or an=1111 for 20 cycles mid-scan -> no state change and no pulses; the frame completes normally afterwards.
